instr_adder_meter: RTL and testbench

- Parametrised measurement controller for an instrumented adder under test (AUT).
- Drives the AUT operands and selects which operand bit closes the ring oscillator, or toggles that bit externally. Counts synchronised rising edges of the AUT chain output over a programmable window of clock cycles, then optionally checks the AUT sum.
- Sits between the LA/IO control registers and the AUT inside the wrapped project. Generalises the fixed 32-bit single-shot instrumentation to any width, with programmable window, saturation and sum check.

---
 rtl/instr_adder_meter.sv | 191 +++++++++++++++++++
 tb/tb_instr_adder_meter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_adder_meter.sv
// Measurement controller for an instrumented adder: drives operands, closes the ring or toggles one
// operand bit, and counts synchronised chain edges. Optional sum check: INSTR_ADDER_SUM_CHECK_EN.
module instr_adder_meter #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 32,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  input  logic                     mode,
  input  logic [$clog2(WIDTH)-1:0] bit_sel,
  input  logic [WIN_W-1:0]         window,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  input  logic                     chain_out,
  input  logic [WIDTH-1:0]         s_in,
  output logic [WIDTH-1:0]         a_input,
  output logic [WIDTH-1:0]         b_input,
  output logic [WIDTH-1:0]         ring_sel,
  output logic [WIDTH-1:0]         ext_sel,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic                     sum_err
);

  localparam int SEL_W = $clog2(WIDTH);
  localparam int PH_W  = $clog2(SYNC_STAGES + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DRAIN,
`ifdef INSTR_ADDER_SUM_CHECK_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       aReg_q;
  logic [WIDTH-1:0]       bReg_q;
  logic [WIDTH-1:0]       aDrive_q;
  logic [WIDTH-1:0]       ringSel_q;
  logic [WIDTH-1:0]       extSel_q;
  logic                   mode_q;
  logic [SEL_W-1:0]       sel_q;
  logic [WIN_W-1:0]       winCnt_q;
  logic [PH_W-1:0]        phase_q;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prevSync_q;

  logic [SEL_W-1:0]       selClamp_d;
  logic [WIDTH-1:0]       selOneHot_d;
  logic                   rise_d;
  logic                   runEnd_d;

  // Out-of-range bit selects fall back to the operand MSB.
  assign selClamp_d  = ({1'b0, bit_sel} >= (SEL_W + 1)'(WIDTH)) ? SEL_W'(WIDTH - 1) : bit_sel;
  assign selOneHot_d = WIDTH'(1) << selClamp_d;
  assign rise_d      = sync_q[SYNC_STAGES-1] & ~prevSync_q;
  assign runEnd_d    = ((state_q == SETTLE) && (phase_q == PH_W'(SYNC_STAGES)) && (winCnt_q == '0)) ||
                       ((state_q == RUN) && (winCnt_q == WIN_W'(1)));

`ifdef INSTR_ADDER_SUM_CHECK_EN
  logic             sumErr_q;
  logic [WIDTH-1:0] expSum_d;
  assign expSum_d = aReg_q + bReg_q;
  assign sum_err  = sumErr_q;
`else
  logic unusedSum;
  assign unusedSum = ^s_in;
  assign sum_err   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      aReg_q     <= '0;
      bReg_q     <= '0;
      aDrive_q   <= '0;
      ringSel_q  <= '0;
      extSel_q   <= '0;
      mode_q     <= 1'b0;
      sel_q      <= '0;
      winCnt_q   <= '0;
      phase_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sync_q     <= '0;
      prevSync_q <= 1'b0;
`ifdef INSTR_ADDER_SUM_CHECK_EN
      sumErr_q   <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], chain_out};
      prevSync_q <= sync_q[SYNC_STAGES-1];

      case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          aReg_q     <= a_in;
          bReg_q     <= b_in;
          aDrive_q   <= a_in;
          mode_q     <= mode;
          sel_q      <= selClamp_d;
          count_q    <= '0;
          overflow_q <= 1'b0;
`ifdef INSTR_ADDER_SUM_CHECK_EN
          sumErr_q   <= 1'b0;
`endif
          winCnt_q   <= window;
          phase_q    <= '0;
          ringSel_q  <= mode ? '0 : selOneHot_d;
          extSel_q   <= mode ? selOneHot_d : '0;
          state_q    <= SETTLE;
        end
        SETTLE: begin
          if (mode_q) aDrive_q[sel_q] <= ~aDrive_q[sel_q];
          if (phase_q == PH_W'(SYNC_STAGES)) begin
            phase_q <= '0;
            state_q <= (winCnt_q == '0) ? DRAIN : RUN;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        RUN: begin
          if (mode_q) aDrive_q[sel_q] <= ~aDrive_q[sel_q];
          if (rise_d) begin
            if (&count_q) overflow_q <= 1'b1;
            else          count_q    <= count_q + CNT_W'(1);
          end
          winCnt_q <= winCnt_q - WIN_W'(1);
          if (winCnt_q == WIN_W'(1)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (phase_q == PH_W'(SYNC_STAGES - 1)) begin
            phase_q <= '0;
`ifdef INSTR_ADDER_SUM_CHECK_EN
            state_q <= CHECK;
`else
            state_q <= DONE;
`endif
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
`ifdef INSTR_ADDER_SUM_CHECK_EN
        CHECK: begin
          if (phase_q == PH_W'(1)) begin
            sumErr_q <= (s_in != expSum_d);
            state_q  <= DONE;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Leaving the measurement window releases the AUT and parks operand a on its loaded value.
      if (runEnd_d) begin
        ringSel_q <= '0;
        extSel_q  <= '0;
        aDrive_q  <= aReg_q;
      end
    end
  end

  assign a_input  = aDrive_q;
  assign b_input  = bReg_q;
  assign ring_sel = ringSel_q;
  assign ext_sel  = extSel_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instr_adder_meter.sv
// Self-checking bench for instr_adder_meter: a default 32-bit instance plus a 20-bit / 4-bit-counter
// instance for clamping and saturation, checked against a cycle-sequence model of the measurement.
module tb_instr_adder_meter;

  localparam int MW         = 32;
  localparam int SW         = 20;
  localparam int SETTLE_CYC = 3;
  localparam int SYNC       = 2;
  localparam int DRAIN_CYC  = 2;
  localparam int LIMIT      = 1000;
`ifdef INSTR_ADDER_SUM_CHECK_EN
  localparam bit SUM_CHK = 1'b1;
`else
  localparam bit SUM_CHK = 1'b0;
`endif
  localparam int CHECK_CYC = SUM_CHK ? 2 : 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sqWave = 1'b0;

  logic        mStart, mMode, mChain, mBusy, mDone, mOvf, mSumErr;
  logic [4:0]  mBitSel, mLoopBit;
  logic [15:0] mWindow;
  logic [31:0] mA, mB, mS, mAInput, mBInput, mRing, mExt, mCount;
  bit          mUseLoop;

  logic        sStart, sMode, sChain, sBusy, sDone, sOvf, sSumErr;
  logic [4:0]  sBitSel, sLoopBit;
  logic [15:0] sWindow;
  logic [19:0] sA, sB, sS, sAInput, sBInput, sRing, sExt;
  logic [3:0]  sCount;

  int busyCyc, doneCnt, ringBad, extBad, aBad;
  bit timedOut;
  logic [63:0] finCount;
  logic        finOvf, finSumErr;
  logic [31:0] finA, finB;

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;
  always #20 sqWave = ~sqWave;

  assign mChain = mUseLoop ? mAInput[mLoopBit] : sqWave;
  assign sChain = sAInput[sLoopBit];

  instr_adder_meter dutMain (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(mStart), .mode(mMode), .bit_sel(mBitSel),
    .window(mWindow), .a_in(mA), .b_in(mB), .chain_out(mChain), .s_in(mS),
    .a_input(mAInput), .b_input(mBInput), .ring_sel(mRing), .ext_sel(mExt), .busy(mBusy),
    .done(mDone), .count(mCount), .overflow(mOvf), .sum_err(mSumErr)
  );

  instr_adder_meter #(.WIDTH(SW), .CNT_W(4)) dutSmall (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(sStart), .mode(sMode), .bit_sel(sBitSel),
    .window(sWindow), .a_in(sA), .b_in(sB), .chain_out(sChain), .s_in(sS),
    .a_input(sAInput), .b_input(sBInput), .ring_sel(sRing), .ext_sel(sExt), .busy(sBusy),
    .done(sDone), .count(sCount), .overflow(sOvf), .sum_err(sSumErr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chain seen by the counter in ext loopback: operand bit toggles every cycle from the first
  // SETTLE cycle; an edge counts in a RUN cycle once it has crossed the synchroniser.
  function automatic longint extEdges(input bit a0, input int win);
    bit chain[$];
    longint n = 0;
    for (int c = 0; c < SETTLE_CYC + win; c++) chain.push_back(a0 ^ c[0]);
    for (int t = SETTLE_CYC; t < SETTLE_CYC + win; t++)
      if (chain[t-SYNC] && !chain[t-SYNC-1]) n++;
    return n;
  endfunction

  task automatic applyStimulus(input bit useSmall, input bit md, input bit loop, input int sel,
                               input int win, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] s, input bit pokeStart);
    int width, effSel, k;
    logic [31:0] expOne, expA, aM, obsA, obsR, obsE;
    logic obsBusy, obsDone;
    bit inWin;
    width  = useSmall ? SW : MW;
    effSel = (sel >= width) ? width - 1 : sel;
    expOne = 32'd1 << effSel;
    aM     = useSmall ? (a & 32'h000F_FFFF) : a;
    @(negedge clk);
    if (useSmall) begin
      sMode = md; sBitSel = 5'(sel); sWindow = 16'(win);
      sA = a[19:0]; sB = b[19:0]; sS = s[19:0]; sLoopBit = 5'(effSel); sStart = 1'b1;
    end else begin
      mMode = md; mBitSel = 5'(sel); mWindow = 16'(win);
      mA = a; mB = b; mS = s; mUseLoop = loop; mLoopBit = 5'(effSel); mStart = 1'b1;
    end
    @(negedge clk);
    mStart = 1'b0; sStart = 1'b0;
    busyCyc = 0; doneCnt = 0; ringBad = 0; extBad = 0; aBad = 0;
    k = 0;
    while (k < LIMIT) begin
      if (useSmall) begin
        obsBusy = sBusy; obsDone = sDone;
        obsA = 32'(sAInput); obsR = 32'(sRing); obsE = 32'(sExt);
      end else begin
        obsBusy = mBusy; obsDone = mDone; obsA = mAInput; obsR = mRing; obsE = mExt;
      end
      if (!obsBusy) break;
      busyCyc++;
      if (obsDone) doneCnt++;
      inWin = (k >= 1) && (k <= SETTLE_CYC + win);
      if (obsR !== ((inWin && !md) ? expOne : 32'd0)) ringBad++;
      if (obsE !== ((inWin && md) ? expOne : 32'd0)) extBad++;
      if (inWin) begin
        expA = (md && (k % 2 == 0)) ? (aM ^ expOne) : aM;
        if (obsA !== expA) aBad++;
      end
      if (pokeStart && k == 8) begin mStart = 1'b1; sStart = 1'b1; end
      if (k == 9) begin mStart = 1'b0; sStart = 1'b0; end
      @(negedge clk);
      k++;
    end
    mStart = 1'b0; sStart = 1'b0;
    timedOut  = (k >= LIMIT);
    finCount  = useSmall ? 64'(sCount) : 64'(mCount);
    finOvf    = useSmall ? sOvf : mOvf;
    finSumErr = useSmall ? sSumErr : mSumErr;
    finA      = useSmall ? 32'(sAInput) : mAInput;
    finB      = useSmall ? 32'(sBInput) : mBInput;
  endtask

  task automatic checkRun(input string tag, input bit useSmall, input bit modelCount, input int sel,
                          input int win, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s);
    int width, effSel;
    logic [31:0] mask, aM, bM, sM, sumM;
    longint edges, maxCnt, expCount;
    bit expOvf, expErr;
    width  = useSmall ? SW : MW;
    effSel = (sel >= width) ? width - 1 : sel;
    mask   = useSmall ? 32'h000F_FFFF : 32'hFFFF_FFFF;
    aM = a & mask; bM = b & mask; sM = s & mask;
    sumM     = (aM + bM) & mask;
    edges    = extEdges(aM[effSel], win);
    maxCnt   = useSmall ? 64'd15 : 64'hFFFF_FFFF;
    expCount = (edges > maxCnt) ? maxCnt : edges;
    expOvf   = (edges > maxCnt);
    expErr   = SUM_CHK && (sM != sumM);
    checkOutput({tag, "_timeout"}, 64'(timedOut), 64'd0);
    checkOutput({tag, "_busyCycles"}, 64'(busyCyc),
                64'(1 + SETTLE_CYC + win + DRAIN_CYC + CHECK_CYC + 1));
    checkOutput({tag, "_doneCount"}, 64'(doneCnt), 64'd1);
    checkOutput({tag, "_ringSelErrs"}, 64'(ringBad), 64'd0);
    checkOutput({tag, "_extSelErrs"}, 64'(extBad), 64'd0);
    checkOutput({tag, "_aInputErrs"}, 64'(aBad), 64'd0);
    if (modelCount) begin
      checkOutput({tag, "_count"}, finCount, 64'(expCount));
      checkOutput({tag, "_overflow"}, 64'(finOvf), 64'(expOvf));
    end
    checkOutput({tag, "_sumErr"}, 64'(finSumErr), 64'(expErr));
    checkOutput({tag, "_aRestored"}, 64'(finA), 64'(aM));
    checkOutput({tag, "_bInput"}, 64'(finB), 64'(bM));
  endtask

  initial begin
    logic [31:0] ra, rb, rs;
    int rsel, rwin;
    bit doneSeen;
    mStart = 0; mMode = 0; mBitSel = 0; mLoopBit = 0; mWindow = 0; mA = 0; mB = 0; mS = 0;
    mUseLoop = 1;
    sStart = 0; sMode = 0; sBitSel = 0; sLoopBit = 0; sWindow = 0; sA = 0; sB = 0; sS = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(mBusy), 64'd0);
    checkOutput("rst_done", 64'(mDone), 64'd0);
    checkOutput("rst_count", 64'(mCount), 64'd0);
    checkOutput("rst_ringSel", 64'(mRing), 64'd0);
    checkOutput("rst_extSel", 64'(mExt), 64'd0);
    checkOutput("rst_aInput", 64'(mAInput), 64'd0);
    checkOutput("rst_overflow", 64'(mOvf), 64'd0);
    checkOutput("rst_smallBusy", 64'(sBusy), 64'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 5, 100, 32'd0, 32'd0, 32'd0, 1'b0);
    checkRun("extLoop", 1'b0, 1'b1, 5, 100, 32'd0, 32'd0, 32'd0);
    checkOutput("extLoop_count50", finCount, 64'd50);

    applyStimulus(1'b0, 1'b0, 1'b0, 26, 64, 32'd0, 32'd0, 32'd0, 1'b0);
    checkRun("ring", 1'b0, 1'b0, 26, 64, 32'd0, 32'd0, 32'd0);
    checkOutput("ring_count16pm1", 64'(finCount >= 64'd15 && finCount <= 64'd17), 64'd1);
    checkOutput("ring_overflow", 64'(finOvf), 64'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 3, 40, 32'd0, 32'd0, 32'd0, 1'b0);
    checkRun("sat", 1'b1, 1'b1, 3, 40, 32'd0, 32'd0, 32'd0);
    checkOutput("sat_count15", finCount, 64'd15);
    checkOutput("sat_overflow", 64'(finOvf), 64'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 31, 10, 32'h0005_A5A5, 32'h3, 32'h0005_A5A8, 1'b0);
    checkRun("clamp", 1'b1, 1'b1, 31, 10, 32'h0005_A5A5, 32'h3, 32'h0005_A5A8);

    applyStimulus(1'b0, 1'b1, 1'b1, 7, 0, 32'h1234_5678, 32'h9, 32'h1234_5681, 1'b0);
    checkRun("win0", 1'b0, 1'b1, 7, 0, 32'h1234_5678, 32'h9, 32'h1234_5681);
    checkOutput("win0_countZero", finCount, 64'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 9, 30, 32'hCAFE_0000, 32'h1, 32'hCAFE_0001, 1'b1);
    checkRun("startWhileBusy", 1'b0, 1'b1, 9, 30, 32'hCAFE_0000, 32'h1, 32'hCAFE_0001);

    // Abort in the middle of RUN: everything returns to zero and no done follows.
    @(negedge clk);
    mMode = 1; mBitSel = 5; mLoopBit = 5; mWindow = 100; mA = 32'h0F0F_0F0F; mB = 0;
    mUseLoop = 1; mStart = 1;
    @(negedge clk);
    mStart = 0;
    repeat (20) @(negedge clk);
    checkOutput("midRun_busy", 64'(mBusy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRst_busy", 64'(mBusy), 64'd0);
    checkOutput("midRst_extSel", 64'(mExt), 64'd0);
    checkOutput("midRst_ringSel", 64'(mRing), 64'd0);
    checkOutput("midRst_count", 64'(mCount), 64'd0);
    checkOutput("midRst_aInput", 64'(mAInput), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      doneSeen = doneSeen | mDone | mBusy;
    end
    checkOutput("midRst_noDone", 64'(doneSeen), 64'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 0, 4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    checkRun("sumOk", 1'b0, 1'b1, 0, 4, 32'hFFFF_FFFF, 32'h1, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 4, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    checkRun("sumBad", 1'b0, 1'b1, 0, 4, 32'hFFFF_FFFF, 32'h1, 32'h1);

    for (int i = 0; i < 6; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rs   = ($urandom_range(0, 1) == 1) ? (ra + rb) : $urandom;
      rsel = $urandom_range(0, 31);
      rwin = $urandom_range(0, 120);
      applyStimulus(1'b0, 1'b1, 1'b1, rsel, rwin, ra, rb, rs, 1'b0);
      checkRun("rand", 1'b0, 1'b1, rsel, rwin, ra, rb, rs);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
